// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the RV32I integer register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [XLEN_DEFAULT-1:0]          xlen_t;
  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations from decode set a busy bit,
// writebacks clear it. A reservation and a write to the same register in
// the same cycle leave the register busy (new producer issued while the
// old one retires). A reservation on an already-busy register raises a
// sticky error flag that only reset clears. Register 0 is never busy.
module regfile_scoreboard #(
  parameter int NREGS  = 32,
  parameter int NUM_WR = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [NREGS-1:0]     busy_vec,
  output logic                 rsv_ok,
  output logic                 rsv_err
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             err_q, err_d;

  // Next busy state: writes clear first, then a reservation sets (reservation wins).
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en && (rsv_addr != '0)) begin
      if (busy_q[rsv_addr]) begin
        err_d = 1'b1;
      end
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard and sticky error flops, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec = busy_q;
  assign rsv_err  = err_q;
  assign rsv_ok   = (rsv_addr == '0) | ~busy_q[rsv_addr];

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with busy scoreboard.
// NUM_RD combinational read ports, NUM_WR synchronous write ports
// (highest-indexed port wins on an address collision). Register 0 is
// hardwired to zero.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the busy clear it implies) onto the read ports.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic                   rsv_ok,
  output logic                   rsv_err,
  output logic [NREGS-1:0]       busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec),
    .rsv_ok   (rsv_ok),
    .rsv_err  (rsv_err)
  );

  // Apply write ports in ascending order so the highest-indexed port wins.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // Register array update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]   addr_w;
      logic [XLEN-1:0] data_c;
      logic            busy_c;
`ifdef REGFILE_BYPASS_EN
      logic            hit_c;
`endif

      assign addr_w = rd_addr[gi*AW +: AW];

      // Read mux: registered contents, optional write forwarding, x0 forced to zero.
      always_comb begin
        data_c = regs_q[addr_w];
        busy_c = busy_vec[addr_w];
`ifdef REGFILE_BYPASS_EN
        hit_c  = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == addr_w)) begin
            data_c = wr_data[j*XLEN +: XLEN];
            hit_c  = 1'b1;
          end
        end
        if (hit_c && !(rsv_en && (rsv_addr == addr_w))) begin
          busy_c = 1'b0;
        end
`endif
        if (addr_w == '0) begin
          data_c = '0;
          busy_c = 1'b0;
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = data_c;
      assign rd_busy[gi]              = busy_c;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: a behavioural register/scoreboard
// model checked every cycle, plus literal expectations for directed cases.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic                   rsv_ok;
  logic                   rsv_err;
  logic [NREGS-1:0]       busy_vec;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // Model state
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_err;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok), .rsv_err(rsv_err), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] wa(int j);
    return wr_addr[j*AW +: AW];
  endfunction

  function automatic logic [XLEN-1:0] wd(int j);
    return wr_data[j*XLEN +: XLEN];
  endfunction

  // Model update: the architectural effect of one clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      if (rsv_en && rsv_addr != 0 && m_busy[rsv_addr]) m_err = 1'b1;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wa(j) != 0) begin
          m_regs[wa(j)] = wd(j);
          m_busy[wa(j)] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j] && wa(j) == a) v = wd(j);
`endif
    return v;
  endfunction

  function automatic logic exp_busy(logic [AW-1:0] a);
    logic b;
    if (a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j] && wa(j) == a && !(rsv_en && rsv_addr == a)) b = 1'b0;
`endif
    return b;
  endfunction

  // Compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      logic [NREGS-1:0] bv;
      for (int r = 0; r < NREGS; r++) bv[r] = m_busy[r];
      for (int i = 0; i < NUM_RD; i++) begin
        logic [AW-1:0] a;
        a = rd_addr[i*AW +: AW];
        n_checks++;
        if (rd_data[i*XLEN +: XLEN] !== exp_data(a)) begin
          n_fail++;
          $display("FAIL model_rd_data port%0d addr %0d: got %h expected %h at %0t",
                   i, a, rd_data[i*XLEN +: XLEN], exp_data(a), $time);
        end
        n_checks++;
        if (rd_busy[i] !== exp_busy(a)) begin
          n_fail++;
          $display("FAIL model_rd_busy port%0d addr %0d: got %b expected %b at %0t",
                   i, a, rd_busy[i], exp_busy(a), $time);
        end
      end
      n_checks++;
      if (busy_vec !== bv) begin
        n_fail++;
        $display("FAIL model_busy_vec: got %h expected %h at %0t", busy_vec, bv, $time);
      end
      n_checks++;
      if (rsv_ok !== ((rsv_addr == 0) || !m_busy[rsv_addr])) begin
        n_fail++;
        $display("FAIL model_rsv_ok: got %b at %0t", rsv_ok, $time);
      end
      n_checks++;
      if (rsv_err !== m_err) begin
        n_fail++;
        $display("FAIL model_rsv_err: got %b expected %b at %0t", rsv_err, m_err, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    rsv_en = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic wr0(input int a, input logic [XLEN-1:0] d);
    wr_en[0] = 1'b1;
    wr_addr[0 +: AW] = AW'(a);
    wr_data[0 +: XLEN] = d;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    checking = 1'b1;

    // Fill registers and reserve each as it is written
    for (int r = 1; r < NREGS; r++) begin
      idle();
      wr0(r, XLEN'(r) * 32'h1111_1111);
      rsv_en = 1'b1;
      rsv_addr = AW'(r);
      tick();
    end
    idle();
    rd(2, 31);
    #1;
    chk("fill_reg2", rd_data[0 +: XLEN], 32'h2222_2222);
    chk("fill_reg31", rd_data[XLEN +: XLEN], 32'h1111_110F);
    chk("fill_busy_vec", busy_vec, 32'hFFFF_FFFE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      rd(r, NREGS - 1 - r);
      #1;
      if (r == 0 || r == 17 || r == 31) chk($sformatf("reset_reg%0d", r), rd_data[0 +: XLEN], 32'h0);
    end
    chk("reset_busy_vec", busy_vec, 32'h0);
    chk("reset_rsv_err", 32'(rsv_err), 32'h0);

    // Write port priority
    wr_en = 2'b11;
    wr_addr = {AW'(5), AW'(5)};
    wr_data = {32'h5555_FFFF, 32'hAAAA_0000};
    tick();
    idle();
    rd(5, 0);
    #1;
    chk("prio_reg5", rd_data[0 +: XLEN], 32'h5555_FFFF);
    wr0(0, 32'hDEAD_BEEF);
    tick();
    idle();
    #1;
    chk("x0_write_ignored", rd_data[XLEN +: XLEN], 32'h0);

    // Reservation lifecycle on reg 7
    rsv_en = 1'b1;
    rsv_addr = 7;
    tick();
    idle();
    rd(7, 7);
    #1;
    chk("rsv7_rd_busy", 32'(rd_busy), 32'h3);
    chk("rsv7_busy_vec", busy_vec, 32'h0000_0080);
    rsv_addr = 7;
    #1;
    chk("rsv7_ok_low", 32'(rsv_ok), 32'h0);
    rsv_addr = 0;
    #1;
    chk("rsv0_ok_high", 32'(rsv_ok), 32'h1);
    rsv_en = 1'b1;
    rsv_addr = 7;
    tick();
    idle();
    #1;
    chk("rsv7_again_err", 32'(rsv_err), 32'h1);
    chk("rsv7_again_busy", busy_vec, 32'h0000_0080);
    wr0(7, 32'h1234);
    tick();
    idle();
    #1;
    chk("wb7_busy_clear", 32'(busy_vec[7]), 32'h0);
    chk("wb7_data", rd_data[0 +: XLEN], 32'h1234);

    // Same-cycle reserve and write on reg 9
    rsv_en = 1'b1;
    rsv_addr = 9;
    tick();
    idle();
    wr0(9, 32'h42);
    rsv_en = 1'b1;
    rsv_addr = 9;
    tick();
    idle();
    rd(9, 0);
    #1;
    chk("same_cycle_reg9", rd_data[0 +: XLEN], 32'h42);
    chk("same_cycle_busy9", 32'(busy_vec[9]), 32'h1);

    // Forwarding versus registered read on reg 3
    wr0(3, 32'h10);
    tick();
    idle();
    rd(3, 3);
    wr0(3, 32'h99);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", rd_data[0 +: XLEN], 32'h99);
`else
    chk("nobypass_same_cycle", rd_data[0 +: XLEN], 32'h10);
`endif
    tick();
    idle();
    #1;
    chk("after_write_reg3", rd_data[0 +: XLEN], 32'h99);

    // Reset overrides a same-cycle write and reservation
    rst = 1'b1;
    wr0(4, 32'hFF);
    rsv_en = 1'b1;
    rsv_addr = 4;
    tick();
    rst = 1'b0;
    idle();
    rd(4, 4);
    #1;
    chk("rst_mid_reg4", rd_data[0 +: XLEN], 32'h0);
    chk("rst_mid_busy4", 32'(busy_vec[4]), 32'h0);

    // Mixed traffic on a few registers, checked by the model each cycle
    for (int k = 0; k < 300; k++) begin
      wr_en = 2'($urandom_range(0, 3));
      wr_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom};
      rsv_en = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom_range(0, 7));
      rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      tick();
    end
    idle();
    tick();
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
